// File: rtl/clk_switch_ctrl.sv
`default_nettype none
// =============================================================================
// clk_switch_ctrl : break-before-make N-way glitch-free clock-source sequencer
// Revision 1.0
// =============================================================================
module clk_switch_ctrl #(
   parameter int NUM_CLKS       = 4,
   parameter int SEL_W          = $clog2(NUM_CLKS),
   parameter int DEFAULT_SEL    = 0,
   parameter int DEAD_CYCLES    = 8,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                test_mode_i,
   input  logic [SEL_W-1:0]    sel_i,
   input  logic                sel_valid_i,
   output logic                sel_ready_o,
   input  logic [NUM_CLKS-1:0] clk_active_i,
   output logic [NUM_CLKS-1:0] clk_en_o,
   output logic [SEL_W-1:0]    clk_selected_o,
   output logic                switching_o,
   output logic                error_o,
   input  logic                err_clr_i
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int DW = $clog2(DEAD_CYCLES + 1);

   localparam logic [SEL_W-1:0]    c_DEF_SEL   = SEL_W'(DEFAULT_SEL);
   localparam logic [NUM_CLKS-1:0] c_ONE       = NUM_CLKS'(1);
   localparam logic [TW-1:0]       c_TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]       c_TMO_SAT   = TW'(TIMEOUT_CYCLES);
   localparam logic [DW-1:0]       c_DEAD_LOAD = DW'(DEAD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DISABLE = 2'd1,
      S_DEAD    = 2'd2,
      S_ENABLE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NUM_CLKS-1:0] r_act_s1;
   logic [NUM_CLKS-1:0] r_act_s2;
   logic [SEL_W-1:0]    r_cur;
   logic [SEL_W-1:0]    w_cur_nxt;
   logic [SEL_W-1:0]    r_target;
   logic [SEL_W-1:0]    w_target_nxt;
   logic [NUM_CLKS-1:0] r_clk_en;
   logic [NUM_CLKS-1:0] w_clk_en_nxt;
   logic [TW-1:0]       r_tmo_cnt;
   logic [TW-1:0]       w_tmo_cnt_nxt;
   logic [TW-1:0]       w_tmo_inc;
   logic [DW-1:0]       r_dead_cnt;
   logic [DW-1:0]       w_dead_cnt_nxt;
   logic                r_error;
   logic                w_err_set;
   logic                w_accept;
   logic                w_sel_invalid;
   logic                w_tmo_hit;

   // Out-of-range selects can only occur when NUM_CLKS is not a power of two.
   generate
      if ((2 ** SEL_W) > NUM_CLKS) begin : g_sel_chk
         assign w_sel_invalid = (sel_i > SEL_W'(NUM_CLKS - 1));
      end else begin : g_sel_full
         assign w_sel_invalid = 1'b0;
      end
   endgenerate

   assign sel_ready_o = (r_state == S_IDLE) && !test_mode_i;
   assign w_accept    = sel_valid_i && sel_ready_o;
   assign w_tmo_hit   = (r_tmo_cnt >= c_TMO_LAST);
   assign w_tmo_inc   = (r_tmo_cnt == c_TMO_SAT) ? r_tmo_cnt : r_tmo_cnt + TW'(1);

   always_comb begin
      w_state_nxt    = r_state;
      w_cur_nxt      = r_cur;
      w_target_nxt   = r_target;
      w_clk_en_nxt   = r_clk_en;
      w_tmo_cnt_nxt  = r_tmo_cnt;
      w_dead_cnt_nxt = r_dead_cnt;
      w_err_set      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (test_mode_i) begin
               w_cur_nxt    = c_DEF_SEL;
               w_clk_en_nxt = c_ONE << c_DEF_SEL;
            end else begin
               w_clk_en_nxt = c_ONE << r_cur;
               if (w_accept) begin
                  if (w_sel_invalid) begin
                     w_err_set = 1'b1;
                  end else if (sel_i != r_cur) begin
                     w_target_nxt  = sel_i;
                     w_state_nxt   = S_DISABLE;
                     w_clk_en_nxt  = '0;
                     w_tmo_cnt_nxt = '0;
                  end
               end
            end
         end
         S_DISABLE: begin
            w_clk_en_nxt  = '0;
            w_tmo_cnt_nxt = w_tmo_inc;
            if (!r_act_s2[r_cur] || w_tmo_hit) begin
               w_err_set      = r_act_s2[r_cur];
               w_state_nxt    = S_DEAD;
               w_dead_cnt_nxt = c_DEAD_LOAD;
            end
         end
         S_DEAD: begin
            if (r_dead_cnt == '0) begin
               w_state_nxt   = S_ENABLE;
               w_clk_en_nxt  = c_ONE << r_target;
               w_tmo_cnt_nxt = '0;
            end else begin
               w_dead_cnt_nxt = r_dead_cnt - DW'(1);
            end
         end
         S_ENABLE: begin
            w_tmo_cnt_nxt = w_tmo_inc;
            // A timed-out source stays enabled; no rollback to the old one.
            if (r_act_s2[r_target] || w_tmo_hit) begin
               w_err_set   = !r_act_s2[r_target];
               w_state_nxt = S_IDLE;
               w_cur_nxt   = r_target;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_act_s1   <= '0;
         r_act_s2   <= '0;
         r_cur      <= c_DEF_SEL;
         r_target   <= c_DEF_SEL;
         r_clk_en   <= c_ONE << c_DEF_SEL;
         r_tmo_cnt  <= '0;
         r_dead_cnt <= '0;
         r_error    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_act_s1   <= clk_active_i;
         r_act_s2   <= r_act_s1;
         r_cur      <= w_cur_nxt;
         r_target   <= w_target_nxt;
         r_clk_en   <= w_clk_en_nxt;
         r_tmo_cnt  <= w_tmo_cnt_nxt;
         r_dead_cnt <= w_dead_cnt_nxt;
         if (w_err_set) begin
            r_error <= 1'b1;
         end else if (err_clr_i) begin
            r_error <= 1'b0;
         end
      end
   end

   assign clk_en_o       = r_clk_en;
   assign clk_selected_o = r_cur;
   assign switching_o    = (r_state != S_IDLE);
   assign error_o        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_clk_switch_ctrl.sv
`default_nettype none
// =============================================================================
// tb_clk_switch_ctrl : randomized + directed bench with behavioural reference
// Revision 1.0
// =============================================================================
module tb_clk_switch_ctrl;

   localparam int N   = 4;
   localparam int T   = 256;
   localparam int DC  = 8;
   localparam int DEF = 0;

   localparam int P_IDLE = 0;
   localparam int P_DIS  = 1;
   localparam int P_DEAD = 2;
   localparam int P_ENA  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       tm;
   logic [1:0] sel;
   logic       valid;
   logic       clr;
   logic [3:0] act;
   logic       ready;
   logic [3:0] en;
   logic [1:0] selo;
   logic       sw;
   logic       err;

   logic [1:0] b_sel;
   logic       b_valid;
   logic       b_clr;
   logic       b_tm;
   logic [2:0] b_act;
   logic       b_ready;
   logic [2:0] b_en;
   logic [1:0] b_selo;
   logic       b_sw;
   logic       b_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clk_switch_ctrl #(.NUM_CLKS(N), .DEFAULT_SEL(DEF), .DEAD_CYCLES(DC), .TIMEOUT_CYCLES(T)) u_dut (
      .clk_i(clk), .rst_i(rst), .test_mode_i(tm), .sel_i(sel), .sel_valid_i(valid),
      .sel_ready_o(ready), .clk_active_i(act), .clk_en_o(en), .clk_selected_o(selo),
      .switching_o(sw), .error_o(err), .err_clr_i(clr));

   clk_switch_ctrl #(.NUM_CLKS(3), .DEFAULT_SEL(0), .DEAD_CYCLES(2), .TIMEOUT_CYCLES(8)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .test_mode_i(b_tm), .sel_i(b_sel), .sel_valid_i(b_valid),
      .sel_ready_o(b_ready), .clk_active_i(b_act), .clk_en_o(b_en), .clk_selected_o(b_selo),
      .switching_o(b_sw), .error_o(b_err), .err_clr_i(b_clr));

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
      end
   endtask

   // Clock-source environment: each source's running status follows its enable after a delay.
   int         env_cnt [N];
   int         fall_dly;
   int         rise_dly;
   logic [3:0] stuck_hi;
   logic [3:0] stuck_lo;

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (stuck_hi[i]) begin
            act[i] = 1'b1; env_cnt[i] = 0;
         end else if (stuck_lo[i]) begin
            act[i] = 1'b0; env_cnt[i] = 0;
         end else if (en[i] != act[i]) begin
            env_cnt[i]++;
            if (en[i] && env_cnt[i] >= rise_dly) begin
               act[i] = 1'b1; env_cnt[i] = 0;
            end else if (!en[i] && env_cnt[i] >= fall_dly) begin
               act[i] = 1'b0; env_cnt[i] = 0;
            end
         end else begin
            env_cnt[i] = 0;
         end
      end
   end

   // Reference model: phase plus cycles-spent-in-phase, status seen two edges late.
   int         m_phase;
   int         m_cur;
   int         m_tgt;
   int         m_n;
   bit         m_err;
   bit         m_set;
   logic [3:0] m_s1;
   logic [3:0] m_s2;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = P_IDLE; m_cur = DEF; m_tgt = DEF; m_n = 0; m_err = 1'b0;
         m_s1 = '0; m_s2 = '0;
      end else begin
         m_set = 1'b0;
         case (m_phase)
            P_IDLE: begin
               if (tm) begin
                  m_cur = DEF;
               end else if (valid) begin
                  if (int'(sel) >= N) m_set = 1'b1;
                  else if (int'(sel) != m_cur) begin
                     m_tgt = int'(sel); m_phase = P_DIS; m_n = 0;
                  end
               end
            end
            P_DIS: begin
               m_n++;
               if (!m_s2[m_cur]) begin
                  m_phase = P_DEAD; m_n = 0;
               end else if (m_n == T) begin
                  m_set = 1'b1; m_phase = P_DEAD; m_n = 0;
               end
            end
            P_DEAD: begin
               m_n++;
               if (m_n == DC) begin
                  m_phase = P_ENA; m_n = 0;
               end
            end
            default: begin
               m_n++;
               if (m_s2[m_tgt] || m_n == T) begin
                  m_set = !m_s2[m_tgt]; m_cur = m_tgt; m_phase = P_IDLE;
               end
            end
         endcase
         if (m_set) m_err = 1'b1;
         else if (clr) m_err = 1'b0;
         m_s2 = m_s1;
         m_s1 = act;
      end
   end

   always @(posedge clk) begin
      logic [3:0] exp_en;
      #1;
      if (m_phase == P_IDLE)     exp_en = 4'(1 << m_cur);
      else if (m_phase == P_ENA) exp_en = 4'(1 << m_tgt);
      else                       exp_en = 4'b0000;
      chk("model_en", 32'(en), 32'(exp_en));
      chk("model_sel", 32'(selo), 32'(m_cur));
      chk("model_switching", 32'(sw), 32'(m_phase != P_IDLE));
      chk("model_ready", 32'(ready), 32'((m_phase == P_IDLE) && !tm));
      chk("model_error", 32'(err), 32'(m_err));
      chk("onehot_or_zero", 32'($countones(en) <= 1), 32'd1);
   end

   task automatic request(input int s);
      int k;
      sel = 2'(s); valid = 1'b1;
      k = 0;
      while (!ready && k < 2000) begin
         @(negedge clk); k++;
      end
      if (k >= 2000) chk("ready_timeout", 32'(ready), 32'd1);
      @(negedge clk);
      valid = 1'b0;
   endtask

   // Waits for the switch to finish; requests driven meanwhile must be ignored.
   task automatic wait_idle(output int zeros);
      int k;
      zeros = 0; k = 0;
      while (sw && k < 2 * T + DC + 50) begin
         if (en == 4'b0000) zeros++;
         valid = 1'($urandom_range(0, 1));
         sel   = 2'($urandom_range(0, 3));
         @(negedge clk); k++;
      end
      valid = 1'b0;
      if (k >= 2 * T + DC + 50) chk("idle_timeout", 32'(sw), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=running required=finished");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int zeros;
      int tgt;
      int r;
      rst = 1'b1; tm = 1'b0; sel = '0; valid = 1'b0; clr = 1'b0; act = 4'b0001;
      stuck_hi = '0; stuck_lo = '0; fall_dly = 3; rise_dly = 5;
      for (int i = 0; i < N; i++) env_cnt[i] = 0;
      b_sel = '0; b_valid = 1'b0; b_clr = 1'b0; b_tm = 1'b0; b_act = 3'b001;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_en", 32'(en), 32'h1);
      chk("reset_sel", 32'(selo), 32'h0);
      chk("reset_ready", 32'(ready), 32'h1);
      chk("reset_error", 32'(err), 32'h0);
      chk("reset_switching", 32'(sw), 32'h0);

      // 0 -> 2: 5 cycles confirming stop plus 8 dead cycles with all enables low
      request(2);
      wait_idle(zeros);
      chk("sw02_zero_cycles", 32'(zeros), 32'd13);
      chk("sw02_sel", 32'(selo), 32'd2);
      chk("sw02_en", 32'(en), 32'h4);
      chk("sw02_error", 32'(err), 32'd0);

      request(1);
      wait_idle(zeros);
      stuck_hi[1] = 1'b1;
      request(3);
      wait_idle(zeros);
      stuck_hi = '0;
      chk("tmo_zero_cycles", 32'(zeros), 32'(T + DC));
      chk("tmo_error", 32'(err), 32'd1);
      chk("tmo_en", 32'(en), 32'h8);
      chk("tmo_sel", 32'(selo), 32'd3);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("err_clr", 32'(err), 32'd0);

      request(2);
      wait_idle(zeros);
      tm = 1'b1;
      @(negedge clk);
      chk("tm_ready", 32'(ready), 32'd0);
      chk("tm_en", 32'(en), 32'h1);
      chk("tm_sel", 32'(selo), 32'd0);
      tm = 1'b0;
      repeat (10) @(negedge clk);

      request(2);
      repeat (7) @(negedge clk);
      tm = 1'b1;
      wait_idle(zeros);
      chk("tm_dead_done_en", 32'(en), 32'h4);
      chk("tm_dead_done_sel", 32'(selo), 32'd2);
      @(negedge clk);
      chk("tm_dead_forced_en", 32'(en), 32'h1);
      tm = 1'b0;
      repeat (10) @(negedge clk);

      request(1);
      repeat (7) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_dead_en", 32'(en), 32'h1);
      chk("rst_dead_sw", 32'(sw), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      request(3);
      wait_idle(zeros);
      chk("after_rst_sel", 32'(selo), 32'd3);

      request(2);
      begin
         int k;
         k = 0;
         while (en != 4'b0100 && k < 200) begin
            @(negedge clk); k++;
         end
      end
      #2 rst = 1'b1;
      #1;
      chk("rst_ena_en", 32'(en), 32'h1);
      chk("rst_ena_sel", 32'(selo), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      request(1);
      wait_idle(zeros);
      chk("after_rst2_sel", 32'(selo), 32'd1);
      chk("after_rst2_en", 32'(en), 32'h2);

      // Three-source instance: out-of-range and no-op requests
      b_sel = 2'd3; b_valid = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
      chk("inv_error", 32'(b_err), 32'd1);
      chk("inv_en", 32'(b_en), 32'h1);
      chk("inv_sw", 32'(b_sw), 32'd0);
      b_sel = 2'd0; b_valid = 1'b1;
      @(negedge clk);
      b_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("noop_en", 32'(b_en), 32'h1);
         chk("noop_sw", 32'(b_sw), 32'd0);
         @(negedge clk);
      end
      b_clr = 1'b1;
      @(negedge clk);
      b_clr = 1'b0;
      chk("inv_clr", 32'(b_err), 32'd0);

      for (int it = 0; it < 120; it++) begin
         fall_dly = $urandom_range(1, 6);
         rise_dly = $urandom_range(1, 6);
         tgt = $urandom_range(0, 3);
         r = $urandom_range(0, 9);
         if (r == 0 && tgt != m_cur) stuck_hi[m_cur] = 1'b1;
         if (r == 1) stuck_lo[tgt] = 1'b1;
         request(tgt);
         wait_idle(zeros);
         stuck_hi = '0;
         stuck_lo = '0;
         repeat ($urandom_range(0, 4)) begin
            clr = ($urandom_range(0, 3) == 0);
            @(negedge clk);
         end
         clr = 1'b0;
         if ($urandom_range(0, 9) == 0) begin
            tm = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            tm = 1'b0;
         end
      end

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
